// File: rtl/mem_responder.sv
// Memory-side responder: 8x8 register-file storage behind an R/W/ADR/DIN request
// interface. Each read or write is closed with a four-phase ACK handshake.
module mem_responder (
  input  logic       CLK,
  input  logic       RST,
  input  logic       R,
  input  logic       W,
  input  logic [2:0] ADR,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       ACK,
  output logic       BUSY,
  output logic       ERR
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    READ  = 2'b10,
    RESP  = 2'b11
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] mem [8];
  logic [2:0] adr_q;
  logic [7:0] din_q;
  logic [7:0] dout_q;
  logic       err_q;

  logic       latch_adr;
  logic       latch_din;
  logic       err_nxt;
  logic       mem_we;
  logic       mem_re;

  // NOTE: every output of this block gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    latch_adr = 1'b0;
    latch_din = 1'b0;
    err_nxt   = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    unique case (state)
      IDLE: begin
        if (R && W) begin
          err_nxt = 1'b1;
        end else if (W) begin
          latch_adr = 1'b1;
          latch_din = 1'b1;
          state_nxt = WRITE;
        end else if (R) begin
          latch_adr = 1'b1;
          state_nxt = READ;
        end
      end
      WRITE: begin
        mem_we    = 1'b1;
        state_nxt = RESP;
      end
      READ: begin
        mem_re    = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (!R && !W) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the storage is reset along with the datapath because its contents
  // must read back as zero after reset; this keeps it in flops, not a RAM macro.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
      adr_q  <= 3'd0;
      din_q  <= 8'h00;
      dout_q <= 8'h00;
      err_q  <= 1'b0;
    end else begin
      err_q <= err_nxt;
      if (latch_adr) adr_q <= ADR;
      if (latch_din) din_q <= DIN;
      if (mem_we)    mem[adr_q] <= din_q;
      if (mem_re)    dout_q <= mem[adr_q];
    end
  end

  // Decoded from registered state only, so these never glitch.
  assign ACK  = (state == RESP);
  assign BUSY = (state != IDLE);
  assign ERR  = err_q;
  assign DOUT = dout_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a reference array plus a queue of expected
// read data, popped when ACK shows the read has completed.
module tb_mem_responder;

  logic       CLK = 1'b0;
  logic       RST;
  logic       R;
  logic       W;
  logic [2:0] ADR;
  logic [7:0] DIN;
  logic [7:0] DOUT;
  logic       ACK;
  logic       BUSY;
  logic       ERR;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_mem [8];
  logic [7:0] exp_q [$];
  logic [7:0] last_read;

  mem_responder dut (
    .CLK  (CLK),
    .RST  (RST),
    .R    (R),
    .W    (W),
    .ADR  (ADR),
    .DIN  (DIN),
    .DOUT (DOUT),
    .ACK  (ACK),
    .BUSY (BUSY),
    .ERR  (ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;
    last_read = 8'h00;
  endtask

  // One full handshake; ADR/DIN are scrambled after acceptance to prove only
  // the values sampled in IDLE are used. hold = extra cycles with request high.
  task automatic xact(input bit is_wr, input logic [2:0] a, input logic [7:0] d, input int hold);
    @(negedge CLK);
    R = !is_wr; W = is_wr; ADR = a; DIN = d;
    if (is_wr) model_mem[a] = d;
    else       exp_q.push_back(model_mem[a]);
    @(negedge CLK);
    ADR = ~a; DIN = ~d;
    check("busy_req+1", 8'(BUSY), 8'd1);
    check("ack_early", 8'(ACK), 8'd0);
    @(negedge CLK);
    check("ack_lat2", 8'(ACK), 8'd1);
    if (is_wr) begin
      check("dout_kept_on_write", DOUT, last_read);
    end else begin
      last_read = exp_q.pop_front();
      check($sformatf("rd_data_adr%0d", a), DOUT, last_read);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      check("ack_hold", 8'(ACK), 8'd1);
      check("dout_hold", DOUT, last_read);
    end
    R = 1'b0; W = 1'b0;
    @(negedge CLK);
    check("ack_release", 8'(ACK), 8'd0);
    check("busy_release", 8'(BUSY), 8'd0);
  endtask

  initial begin
    RST = 1'b1; R = 1'b0; W = 1'b0; ADR = 3'd0; DIN = 8'h00;
    clear_model();

    // Reset held for two cycles; outputs must stay quiet throughout.
    repeat (2) begin
      @(negedge CLK);
      check("rst_ack", 8'(ACK), 8'd0);
      check("rst_busy", 8'(BUSY), 8'd0);
      check("rst_err", 8'(ERR), 8'd0);
    end
    check("rst_dout", DOUT, 8'h00);
    RST = 1'b0;
    for (int k = 0; k < 8; k++) xact(1'b0, 3'(k), 8'h00, 0);

    // Basic write then read.
    xact(1'b1, 3'd5, 8'hA7, 1);
    xact(1'b0, 3'd5, 8'h00, 1);

    // Fill every entry, read back in reverse order.
    for (int k = 0; k < 8; k++) xact(1'b1, 3'(k), 8'(8'h10 + k), 0);
    for (int k = 7; k >= 0; k--) xact(1'b0, 3'(k), 8'h00, 0);

    // Request held well past ACK: no re-access, ACK stays up.
    xact(1'b0, 3'd3, 8'h00, 10);

    // Conflicting request in IDLE: one-cycle ERR, no access.
    @(negedge CLK);
    R = 1'b1; W = 1'b1; ADR = 3'd3; DIN = 8'h55;
    @(negedge CLK);
    R = 1'b0; W = 1'b0;
    check("conflict_err", 8'(ERR), 8'd1);
    check("conflict_busy", 8'(BUSY), 8'd0);
    @(negedge CLK);
    check("conflict_err_pulse", 8'(ERR), 8'd0);
    check("conflict_busy2", 8'(BUSY), 8'd0);
    xact(1'b0, 3'd3, 8'h00, 0);

    // Reset during the WRITE cycle: write dropped, whole array cleared.
    @(negedge CLK);
    W = 1'b1; ADR = 3'd2; DIN = 8'hFF;
    @(negedge CLK);
    check("midwr_busy", 8'(BUSY), 8'd1);
    RST = 1'b1; W = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    clear_model();
    check("midwr_busy_after", 8'(BUSY), 8'd0);
    check("midwr_dout", DOUT, 8'h00);
    xact(1'b0, 3'd2, 8'h00, 0);
    xact(1'b0, 3'd7, 8'h00, 0);

    // Reset during RESP: ACK drops on the next cycle.
    @(negedge CLK);
    W = 1'b1; ADR = 3'd4; DIN = 8'h3C;
    @(negedge CLK);
    @(negedge CLK);
    check("midresp_ack", 8'(ACK), 8'd1);
    RST = 1'b1;
    @(negedge CLK);
    check("midresp_ack_drop", 8'(ACK), 8'd0);
    check("midresp_busy", 8'(BUSY), 8'd0);
    RST = 1'b0; W = 1'b0;
    clear_model();
    xact(1'b0, 3'd4, 8'h00, 0);

    // Mid-op scramble inside xact must not redirect this write.
    xact(1'b1, 3'd6, 8'h5A, 0);
    xact(1'b0, 3'd1, 8'h00, 0);
    xact(1'b0, 3'd6, 8'h00, 0);

    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
